ram_shared_arbiter: RTL and testbench

// - Shares one single-port 16x4096 RAM between two requesters: port A (MU0 CPU) and port B (loader/debug/DMA).
// - Round-robin arbitration, one access in flight at a time.
// - Registered read-data return with a readdatavalid strobe.
// - Sits between the requesters and the RAM; hides the RAM's configurable read delay (0 or 1 cycle).

---
 rtl/ram_shared_arbiter_pkg.sv | 31 +++
 rtl/ram_shared_arbiter_rr_arbiter_2.sv | 22 ++
 rtl/ram_shared_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ram_shared_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_shared_arbiter_pkg.sv
// Shared types for the two-port round-robin RAM arbiter.
package ram_arb_pkg;

  // Geometry of the shared RAM; the request latch struct is sized from these.
  localparam int ARB_ADDR_W = 12;
  localparam int ARB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  // One accepted request as held for the duration of the RAM access.
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic                  is_write;
  } ram_req_t;

  // The other requester, used for the round-robin tie break.
  function automatic port_t other_port(input port_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/ram_shared_arbiter_rr_arbiter_2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the
// port that was not granted last. Purely combinational.
module rr_arbiter_2
  import ram_arb_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_t last_grant,
  output port_t grant
);

  // Default to the non-last port so a tie (or no request) favours it.
  always_comb begin
    grant = other_port(last_grant);
    if (req_a && !req_b) begin
      grant = PORT_A;
    end else if (req_b && !req_a) begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/ram_shared_arbiter.sv
// Shares one single-port RAM between requesters A and B. One access in
// flight; registered RAM drive; registered read return with a valid strobe.
module ram_shared_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int READ_LATENCY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic              a_readdatavalid,
  output logic [DATA_W-1:0] a_readdata,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic              b_readdatavalid,
  output logic [DATA_W-1:0] b_readdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);

  if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
    $fatal(1, "ram_shared_arbiter: READ_LATENCY must be 0 or 1");
  end
  if (ADDR_W != ARB_ADDR_W || DATA_W != ARB_DATA_W) begin : g_bad_width
    $fatal(1, "ram_shared_arbiter: ADDR_W/DATA_W must match ram_arb_pkg");
  end

  // Per-port views so the request mux and response steer index by port_t.
  logic [ADDR_W-1:0] p_addr  [2];
  logic [DATA_W-1:0] p_wdata [2];
  logic [1:0]        p_rd, p_wr, p_req, p_wait;
  logic              rvalid_q [2];
  logic [DATA_W-1:0] rdata_q  [2];

  assign p_addr[0]  = a_address;
  assign p_addr[1]  = b_address;
  assign p_wdata[0] = a_writedata;
  assign p_wdata[1] = b_writedata;
  assign p_rd       = {b_read, a_read};
  assign p_wr       = {b_write, a_write};
  assign p_req      = p_rd | p_wr;

  arb_state_t state_q, state_d;
  port_t      last_grant_q, last_grant_d, owner_q, owner_d, grant;
  ram_req_t   req_q, req_d;
  logic       rd_q, rd_d, wr_q, wr_d;
  logic       accept, capture;

  rr_arbiter_2 u_rr (
    .req_a      (p_req[0]),
    .req_b      (p_req[1]),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign accept = (state_q == IDLE) && p_req[grant];
  // Read data is valid in ACCESS for a combinational RAM, in WAIT otherwise.
  assign capture = (READ_LATENCY == 0) ? (state_q == ACCESS && rd_q)
                                       : (state_q == WAIT);

  // Next-state logic: latch the granted request, then walk ACCESS/WAIT.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    req_d        = req_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d        = ACCESS;
          owner_d        = grant;
          last_grant_d   = grant;
          req_d.addr     = p_addr[grant];
          req_d.wdata    = p_wdata[grant];
          req_d.is_write = p_wr[grant];
          // Write wins when a port asserts both; its read is dropped.
          wr_d           = p_wr[grant];
          rd_d           = !p_wr[grant];
        end
      end
      ACCESS: begin
        wr_d = 1'b0;
        if (!req_q.is_write && READ_LATENCY == 1) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
          rd_d    = 1'b0;
          req_d   = '0;
        end
      end
      WAIT: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        req_d   = '0;
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        req_d   = '0;
      end
    endcase
  end

  // Control and request-latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_B;
      owner_q      <= PORT_A;
      req_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      req_q        <= req_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign p_wait[gi] = !(state_q == IDLE && grant == port_t'(1'(gi)));

    // Capture read data for this port when it owns the completing read.
    always_ff @(posedge clk) begin
      if (reset) begin
        rvalid_q[gi] <= 1'b0;
        rdata_q[gi]  <= '0;
      end else begin
        rvalid_q[gi] <= capture && (owner_q == port_t'(1'(gi)));
        if (capture && (owner_q == port_t'(1'(gi)))) begin
          rdata_q[gi] <= ram_readdata;
        end
      end
    end
  end

  assign a_waitrequest   = p_wait[0];
  assign b_waitrequest   = p_wait[1];
  assign a_readdatavalid = rvalid_q[0];
  assign b_readdatavalid = rvalid_q[1];
  assign a_readdata      = rdata_q[0];
  assign b_readdata      = rdata_q[1];

  // The latch is cleared on return to IDLE, so the RAM bus idles at zero.
  assign ram_address   = req_q.addr;
  assign ram_writedata = req_q.wdata;
  assign ram_read      = rd_q;
  assign ram_write     = wr_q;

endmodule

// File: tb/tb_ram_shared_arbiter.sv
// Directed bench: LAT0 instance for the main scenarios, LAT1 instance for
// the registered-RAM read timing. Each instance has its own RAM model.
module tb_ram_shared_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // LAT0 instance signals
  logic [11:0] a_address = '0, b_address = '0;
  logic        a_read = 0, a_write = 0, b_read = 0, b_write = 0;
  logic [15:0] a_writedata = '0, b_writedata = '0;
  logic        a_waitrequest, a_readdatavalid, b_waitrequest, b_readdatavalid;
  logic [15:0] a_readdata, b_readdata;
  logic [11:0] ram_address;
  logic        ram_read, ram_write;
  logic [15:0] ram_writedata, ram_readdata;
  logic [15:0] mem0 [4096];

  // LAT1 instance signals
  logic [11:0] b1_address = '0;
  logic        b1_read = 0;
  logic        a1_waitrequest, a1_readdatavalid, b1_waitrequest, b1_readdatavalid;
  logic [15:0] a1_readdata, b1_readdata;
  logic [11:0] ram1_address;
  logic        ram1_read, ram1_write;
  logic [15:0] ram1_writedata, ram1_readdata;
  logic [15:0] mem1 [4096];

  ram_shared_arbiter #(.ADDR_W(12), .DATA_W(16), .READ_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
    .a_waitrequest(a_waitrequest), .a_readdatavalid(a_readdatavalid), .a_readdata(a_readdata),
    .b_address(b_address), .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
    .b_waitrequest(b_waitrequest), .b_readdatavalid(b_readdatavalid), .b_readdata(b_readdata),
    .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  ram_shared_arbiter #(.ADDR_W(12), .DATA_W(16), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .a_address(12'h000), .a_read(1'b0), .a_write(1'b0), .a_writedata(16'h0000),
    .a_waitrequest(a1_waitrequest), .a_readdatavalid(a1_readdatavalid), .a_readdata(a1_readdata),
    .b_address(b1_address), .b_read(b1_read), .b_write(1'b0), .b_writedata(16'h0000),
    .b_waitrequest(b1_waitrequest), .b_readdatavalid(b1_readdatavalid), .b_readdata(b1_readdata),
    .ram_address(ram1_address), .ram_read(ram1_read), .ram_write(ram1_write),
    .ram_writedata(ram1_writedata), .ram_readdata(ram1_readdata)
  );

  // Combinational-read RAM model
  assign ram_readdata = mem0[ram_address];
  always @(posedge clk) if (ram_write) mem0[ram_address] = ram_writedata;

  // Registered-read RAM model
  always @(posedge clk) begin
    ram1_readdata <= mem1[ram1_address];
    if (ram1_write) mem1[ram1_address] = ram1_writedata;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_data;
  logic        exp_a;
  int          ia, ib;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end
    for (int i = 0; i < 10; i++) begin
      mem0[12'h400 + i] = 16'hA000 + 16'(i);
      mem0[12'h800 + i] = 16'hB000 + 16'(i);
    end
    mem0[12'h200] = 16'h1111;
    mem0[12'h300] = 16'h2222;
    mem0[12'h010] = 16'hFFFF;
    mem1[12'hFFF] = 16'h5A5A;

    // Reset state
    cyc(); cyc();
    check("rst_ram_read", ram_read, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_ram_addr", ram_address, 0);
    check("rst_a_rvalid", a_readdatavalid, 0);
    check("rst_a_rdata", a_readdata, 0);
    check("rst_b_rdata", b_readdata, 0);
    check("rst_a_wait", a_waitrequest, 0);
    check("rst_b_wait", b_waitrequest, 1);
    $display("reset: checked idle outputs");
    reset = 1'b0;
    cyc();

    // A write 0x123 <= 0xBEEF, then read it back
    a_address = 12'h123; a_writedata = 16'hBEEF; a_write = 1; #1;
    check("wr_accept", a_waitrequest, 0);
    cyc();
    a_write = 0;
    check("wr_ram_write", ram_write, 1);
    check("wr_ram_addr", ram_address, 12'h123);
    check("wr_ram_wdata", ram_writedata, 16'hBEEF);
    check("wr_busy_wait", a_waitrequest, 1);
    cyc();
    check("wr_ram_write_off", ram_write, 0);
    check("wr_mem", mem0[12'h123], 16'hBEEF);
    check("wr_no_rvalid", a_readdatavalid, 0);
    $display("txn: A write 0x123 <= 0xBEEF");
    a_read = 1; #1;
    check("rd_accept", a_waitrequest, 0);
    cyc();
    a_read = 0;
    check("rd_ram_read", ram_read, 1);
    check("rd_rvalid_t1", a_readdatavalid, 0);
    cyc();
    check("rd_rvalid_t2", a_readdatavalid, 1);
    check("rd_data", a_readdata, 16'hBEEF);
    check("rd_ram_read_off", ram_read, 0);
    cyc();
    check("rd_rvalid_t3", a_readdatavalid, 0);
    check("rd_data_hold", a_readdata, 16'hBEEF);
    $display("txn: A read 0x123 -> %h", a_readdata);

    // Simultaneous reads right after reset: A first, then B
    reset = 1; cyc(); reset = 0;
    a_address = 12'h200; b_address = 12'h300; a_read = 1; b_read = 1; #1;
    check("tie_a_wait", a_waitrequest, 0);
    check("tie_b_wait", b_waitrequest, 1);
    cyc();
    a_read = 0;
    check("tie_ram_addr_a", ram_address, 12'h200);
    check("tie_b_still_wait", b_waitrequest, 1);
    cyc();
    check("tie_a_rvalid", a_readdatavalid, 1);
    check("tie_a_data", a_readdata, 16'h1111);
    check("tie_b_grant", b_waitrequest, 0);
    cyc();
    b_read = 0;
    check("tie_ram_addr_b", ram_address, 12'h300);
    cyc();
    check("tie_b_rvalid", b_readdatavalid, 1);
    check("tie_b_data", b_readdata, 16'h2222);
    check("tie_a_no_rvalid", a_readdatavalid, 0);
    $display("txn: tie A=%h B=%h", a_readdata, b_readdata);

    // 20 back-to-back contended reads, grants must alternate A,B,...
    ia = 0; ib = 0; exp_a = 0; exp_data = '0;
    for (int k = 0; k < 20; k++) begin
      a_address = 12'h400 + 12'(ia); b_address = 12'h800 + 12'(ib);
      a_read = 1; b_read = 1; #1;
      check("rr_a_wait", a_waitrequest, (k % 2 == 0) ? 0 : 1);
      check("rr_b_wait", b_waitrequest, (k % 2 == 0) ? 1 : 0);
      if (k > 0) begin
        check("rr_a_rvalid", a_readdatavalid, exp_a);
        check("rr_b_rvalid", b_readdatavalid, !exp_a);
        check("rr_rdata", exp_a ? a_readdata : b_readdata, exp_data);
      end
      cyc();
      exp_a = (k % 2 == 0);
      exp_data = exp_a ? 16'hA000 + 16'(ia) : 16'hB000 + 16'(ib);
      check("rr_ram_addr", ram_address, exp_a ? 12'h400 + 12'(ia) : 12'h800 + 12'(ib));
      if (exp_a) ia++; else ib++;
      cyc();
      $display("txn: rr access %0d port=%s data=%h", k, exp_a ? "A" : "B", exp_data);
    end
    a_read = 0; b_read = 0; #1;
    check("rr_last_rvalid", b_readdatavalid, 1);
    check("rr_last_data", b_readdata, 16'hB009);
    check("rr_last_a_quiet", a_readdatavalid, 0);
    cyc();

    // Read and write together: write wins, no response
    a_address = 12'h010; a_writedata = 16'h0001; a_read = 1; a_write = 1; #1;
    check("rw_accept", a_waitrequest, 0);
    cyc();
    a_read = 0; a_write = 0;
    check("rw_ram_write", ram_write, 1);
    check("rw_ram_read", ram_read, 0);
    cyc();
    check("rw_mem", mem0[12'h010], 16'h0001);
    check("rw_no_rvalid0", a_readdatavalid, 0);
    cyc();
    check("rw_no_rvalid1", a_readdatavalid, 0);
    $display("txn: A read+write 0x010 -> mem=%h", mem0[12'h010]);

    // Reset during ACCESS of an A read
    a_address = 12'h123; a_read = 1; #1;
    check("abort_accept", a_waitrequest, 0);
    cyc();
    a_read = 0; reset = 1; #1;
    check("abort_in_access", ram_read, 1);
    cyc();
    check("abort_rvalid", a_readdatavalid, 0);
    check("abort_ram_read", ram_read, 0);
    check("abort_ram_write", ram_write, 0);
    check("abort_ram_addr", ram_address, 0);
    reset = 0;
    cyc();
    check("abort_rvalid_late", a_readdatavalid, 0);
    a_address = 12'h200; b_address = 12'h300; a_read = 1; b_read = 1; #1;
    check("post_abort_a_wins", a_waitrequest, 0);
    check("post_abort_b_wait", b_waitrequest, 1);
    cyc();
    a_read = 0;
    cyc();
    check("post_abort_a_data", a_readdata, 16'h1111);
    check("post_abort_b_grant", b_waitrequest, 0);
    cyc();
    b_read = 0;
    cyc();
    check("post_abort_b_data", b_readdata, 16'h2222);
    $display("txn: reset abort then A=%h B=%h", a_readdata, b_readdata);

    // READ_LATENCY=1: B read 0xFFF
    b1_address = 12'hFFF; b1_read = 1; #1;
    check("l1_accept", b1_waitrequest, 0);
    cyc();
    b1_read = 0;
    check("l1_ram_read_t1", ram1_read, 1);
    check("l1_ram_addr_t1", ram1_address, 12'hFFF);
    check("l1_rvalid_t1", b1_readdatavalid, 0);
    cyc();
    check("l1_ram_read_t2", ram1_read, 1);
    check("l1_rvalid_t2", b1_readdatavalid, 0);
    check("l1_busy_t2", b1_waitrequest, 1);
    cyc();
    check("l1_rvalid_t3", b1_readdatavalid, 1);
    check("l1_data", b1_readdata, 16'h5A5A);
    check("l1_ram_read_off", ram1_read, 0);
    check("l1_a_quiet", a1_readdatavalid, 0);
    cyc();
    check("l1_rvalid_t4", b1_readdatavalid, 0);
    $display("txn: LAT1 B read 0xFFF -> %h", b1_readdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
